// File: rtl/uart_frame_assembler.sv
// Packs bytes from the UART receiver into one FRAME_BYTES-wide frame for the coprocessor.
// Optional idle timeout that drops a stalled partial frame: define FRAME_TIMEOUT_EN.
module uart_frame_assembler #(
  parameter int DBITS          = 8,
  parameter int FRAME_BYTES    = 18,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [DBITS-1:0]                   rx_data,
  input  logic                               rx_valid,
  output logic [FRAME_BYTES*DBITS-1:0]       frame_out,
  output logic                               frame_valid,
  output logic [$clog2(FRAME_BYTES+1)-1:0]   byte_count,
  output logic                               busy,
  output logic                               timeout_drop
);

  localparam int FW = FRAME_BYTES * DBITS;
  localparam int CW = $clog2(FRAME_BYTES + 1);
  localparam logic [CW-1:0] LAST_SLOT = CW'(FRAME_BYTES - 1);

  logic [FW-1:0] shadow;
  logic [FW-1:0] shadow_merged;
  logic          expire;

  // The completing byte is merged combinationally so frame_out lands one cycle after it.
  always_comb begin
    shadow_merged = shadow;
    shadow_merged[byte_count*DBITS +: DBITS] = rx_data;
  end

`ifdef FRAME_TIMEOUT_EN
  localparam int IW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IW-1:0] EXPIRE_AT = IW'(TIMEOUT_CYCLES - 1);

  logic [IW-1:0] idle_cnt;

  // A byte on the expiry cycle wins: expire needs rx_valid low.
  assign expire = busy && !rx_valid && (idle_cnt == EXPIRE_AT);

  always_ff @(posedge clk) begin
    if (rst) begin
      idle_cnt     <= '0;
      timeout_drop <= 1'b0;
    end else begin
      timeout_drop <= expire;
      if (!busy || rx_valid || expire) begin
        idle_cnt <= '0;
      end else begin
        idle_cnt <= idle_cnt + 1'b1;
      end
    end
  end
`else
  assign expire       = 1'b0;
  assign timeout_drop = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow      <= '0;
      frame_out   <= '0;
      frame_valid <= 1'b0;
      byte_count  <= '0;
      busy        <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      if (rx_valid) begin
        if (byte_count == LAST_SLOT) begin
          frame_out   <= shadow_merged;
          frame_valid <= 1'b1;
          shadow      <= '0;
          byte_count  <= '0;
          busy        <= 1'b0;
        end else begin
          shadow      <= shadow_merged;
          byte_count  <= byte_count + 1'b1;
          busy        <= 1'b1;
        end
      end else if (expire) begin
        shadow     <= '0;
        byte_count <= '0;
        busy       <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_frame_assembler.sv
// Bench for uart_frame_assembler: directed scenarios plus random traffic against a queue-based model.
// Timeout scenarios are exercised only when FRAME_TIMEOUT_EN is defined.
module tb_uart_frame_assembler;

  localparam int DB = 8;
  localparam int FB = 18;
  localparam int FW = FB * DB;
  localparam int CW = $clog2(FB + 1);
  localparam int TO = 16;

  logic          clk;
  logic          rst;
  logic [DB-1:0] rx_data;
  logic          rx_valid;
  logic [FW-1:0] frame_out;
  logic          frame_valid;
  logic [CW-1:0] byte_count;
  logic          busy;
  logic          timeout_drop;

  uart_frame_assembler #(
    .DBITS(DB),
    .FRAME_BYTES(FB),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .frame_out(frame_out),
    .frame_valid(frame_valid),
    .byte_count(byte_count),
    .busy(busy),
    .timeout_drop(timeout_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  logic [DB-1:0] q[$];
  logic [FW-1:0] exp_frame;
  bit            exp_fv;
  bit            exp_td;
  int            idle;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input bit v, input logic [DB-1:0] d, input bit r);
    if (r) begin
      q.delete();
      exp_frame = '0;
      exp_fv    = 0;
      exp_td    = 0;
      idle      = 0;
    end else begin
      exp_fv = 0;
      exp_td = 0;
      if (v) begin
        idle = 0;
        q.push_back(d);
        if (q.size() == FB) begin
          exp_frame = '0;
          for (int k = 0; k < FB; k++) exp_frame[k*DB +: DB] = q[k];
          exp_fv = 1;
          q.delete();
        end
      end else if (q.size() != 0) begin
`ifdef FRAME_TIMEOUT_EN
        idle++;
        if (idle == TO) begin
          q.delete();
          exp_td = 1;
          idle   = 0;
        end
`endif
      end else begin
        idle = 0;
      end
    end
  endtask

  task automatic cyc(input bit v, input logic [DB-1:0] d, input bit r);
    rx_valid = v;
    rx_data  = d;
    rst      = r;
    @(posedge clk);
    model_edge(v, d, r);
    #1;
    chk("frame_out",    frame_out,            exp_frame);
    chk("frame_valid",  FW'(frame_valid),     FW'(exp_fv));
    chk("byte_count",   FW'(byte_count),      FW'(q.size()));
    chk("busy",         FW'(busy),            FW'(q.size() != 0));
    chk("timeout_drop", FW'(timeout_drop),    FW'(exp_td));
  endtask

  logic [DB-1:0] f1_first;

  initial begin
    rx_valid = 0;
    rx_data  = '0;
    rst      = 1;
    cyc(0, 8'h00, 1);
    cyc(0, 8'h00, 1);
    cyc(0, 8'h00, 0);

    // Back-to-back frame 0x01..0x12
    for (int i = 1; i <= FB; i++) cyc(1, DB'(i), 0);
    chk("t1_pulse", FW'(frame_valid), FW'(1));
    chk("t1_byte0", FW'(frame_out[7:0]), FW'(8'h01));
    chk("t1_byte17", FW'(frame_out[143:136]), FW'(8'h12));
    cyc(0, 8'h00, 0);
    chk("t1_pulse_gone", FW'(frame_valid), FW'(0));

    // Spaced frame, then a back-to-back frame 0xA0..0xB1
    f1_first = DB'($urandom);
    for (int i = 0; i < FB; i++) begin
      cyc(1, (i == 0) ? f1_first : DB'($urandom), 0);
      if (i != FB - 1) for (int j = 0; j < 6; j++) cyc(0, 8'h00, 0);
    end
    for (int i = 0; i < FB - 1; i++) cyc(1, DB'(8'hA0 + i), 0);
    chk("t2_hold", FW'(frame_out[7:0]), FW'(f1_first));
    cyc(1, 8'hB1, 0);
    chk("t2_second", FW'(frame_out[7:0]), FW'(8'hA0));

`ifdef FRAME_TIMEOUT_EN
    // Partial frame of 5 bytes dropped after TO idle cycles
    for (int i = 0; i < 5; i++) cyc(1, DB'($urandom), 0);
    for (int i = 0; i < TO; i++) cyc(0, 8'h00, 0);
    chk("t3_drop", FW'(timeout_drop), FW'(1));
    chk("t3_count", FW'(byte_count), FW'(0));
    for (int i = 0; i < FB; i++) cyc(1, DB'(8'hC0 + i), 0);
    chk("t3_slot0", FW'(frame_out[7:0]), FW'(8'hC0));

    // Byte on the expiry cycle keeps the frame alive
    for (int i = 0; i < 5; i++) cyc(1, DB'($urandom), 0);
    for (int i = 0; i < TO - 1; i++) cyc(0, 8'h00, 0);
    cyc(1, 8'h3C, 0);
    chk("t4_nodrop", FW'(timeout_drop), FW'(0));
    chk("t4_count", FW'(byte_count), FW'(6));
    cyc(0, 8'h00, 1);
`endif

    // Reset mid-frame, then a frame of 0x55
    for (int i = 0; i < 9; i++) cyc(1, DB'($urandom), 0);
    cyc(0, 8'h00, 1);
    chk("t5_rst_frame", frame_out, '0);
    chk("t5_rst_count", FW'(byte_count), FW'(0));
    for (int i = 0; i < FB; i++) cyc(1, 8'h55, 0);
    chk("t5_all55", frame_out, {FB{8'h55}});

    // Frame immediately followed by the first byte of the next
    for (int i = 0; i < FB; i++) cyc(1, DB'($urandom), 0);
    cyc(1, 8'h77, 0);
    chk("t6_count", FW'(byte_count), FW'(1));
    for (int i = 0; i < FB - 1; i++) cyc(1, DB'(i), 0);
    chk("t6_slot0", FW'(frame_out[7:0]), FW'(8'h77));

    // Random traffic with occasional long gaps and resets
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 59) == 0) begin
        for (int j = 0; j < $urandom_range(10, 24); j++) cyc(0, 8'h00, 0);
      end else begin
        cyc($urandom_range(0, 3) != 0, DB'($urandom), $urandom_range(0, 199) == 0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
